// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the memory-side responder.
// State encoding for the responder FSM plus default geometry/latency.
// The word-counter width helper is derived from the default block size.
package mem_resp_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_WORD_W      = 32;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_LATENCY     = 4;

  localparam int WCNT_W = $clog2(DEF_BLOCK_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_XFER = 3'd2,
    ST_RD_DONE = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_WR_XFER = 3'd5,
    ST_WR_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/mem_block_store.sv
// Word-addressed backing store: 2^ADDR_W blocks of 2^WCNT_W words each.
// Latency: read is combinational, write commits on the rising edge.
// Backpressure: none; one read and one write port, always available.
module mem_block_store #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32,
  parameter int WCNT_W = 2
) (
  input  logic                     clk,
  input  logic [ADDR_W+WCNT_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0]        o_rd_dat,
  input  logic                     i_wr_en,
  input  logic [ADDR_W+WCNT_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0]        i_wr_dat
);

  localparam int DEPTH = 2 ** (ADDR_W + WCNT_W);

  logic [WORD_W-1:0] r_mem [0:DEPTH-1];

  // Synchronous write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for D-cache block fetch / write-back with modelled latency.
// Latency: ready pulses 1+LATENCY+BLOCK_WORDS cycles after the request is sampled in IDLE.
// Backpressure: one request at a time; requests are ignored outside IDLE, write wins ties.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dr_valid,
  input  logic [ADDR_W-1:0]             dr_addr,
  output logic [BLOCK_WORDS*WORD_W-1:0] dr_data,
  output logic                          dr_ready,
  input  logic                          dw_valid,
  input  logic [ADDR_W-1:0]             dw_addr,
  input  logic [BLOCK_WORDS*WORD_W-1:0] dw_data,
  output logic                          dw_ready
);

  localparam int WC_W  = $clog2(BLOCK_WORDS);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(BLOCK_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [LAT_W-1:0]                   r_lat_cnt;
  logic [WC_W-1:0]                    r_wcnt;
  logic [ADDR_W-1:0]                  r_addr;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] r_rd_buf;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] r_wr_buf;
  logic                               r_dr_ready;
  logic                               r_dw_ready;

  logic [WORD_W-1:0] w_store_rd;
  logic              w_store_we;
  logic              w_dr_ready_nxt;
  logic              w_dw_ready_nxt;

  mem_block_store #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .WCNT_W (WC_W)
  ) u_store (
    .clk       (clk),
    .i_rd_addr ({r_addr, r_wcnt}),
    .o_rd_dat  (w_store_rd),
    .i_wr_en   (w_store_we),
    .i_wr_addr ({r_addr, r_wcnt}),
    .i_wr_dat  (r_wr_buf[r_wcnt])
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: accept only in IDLE, count latency, then walk the block words.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dw_valid)      w_state_nxt = ST_WR_WAIT;
        else if (dr_valid) w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (r_lat_cnt == LAT_LAST) w_state_nxt = ST_RD_XFER;
      ST_RD_XFER: if (r_wcnt == WC_LAST)     w_state_nxt = ST_RD_DONE;
      ST_RD_DONE: w_state_nxt = ST_IDLE;
      ST_WR_WAIT: if (r_lat_cnt == LAT_LAST) w_state_nxt = ST_WR_XFER;
      ST_WR_XFER: if (r_wcnt == WC_LAST)     w_state_nxt = ST_WR_DONE;
      ST_WR_DONE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: ready is registered from the next state so it lines up with DONE.
  always_comb begin
    w_dr_ready_nxt = (w_state_nxt == ST_RD_DONE);
    w_dw_ready_nxt = (w_state_nxt == ST_WR_DONE);
    w_store_we     = (r_state == ST_WR_XFER);
  end

  // Registered ready pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dr_ready <= 1'b0;
      r_dw_ready <= 1'b0;
    end else begin
      r_dr_ready <= w_dr_ready_nxt;
      r_dw_ready <= w_dw_ready_nxt;
    end
  end

  // Counters and read line buffer; word counter saturates at the last index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_cnt <= '0;
      r_wcnt    <= '0;
      r_rd_buf  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_lat_cnt <= '0;
          r_wcnt    <= '0;
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          r_wcnt <= '0;
          if (r_lat_cnt != LAT_LAST) r_lat_cnt <= r_lat_cnt + 1'b1;
        end
        ST_RD_XFER: begin
          r_rd_buf[r_wcnt] <= w_store_rd;
          if (r_wcnt != WC_LAST) r_wcnt <= r_wcnt + 1'b1;
        end
        ST_WR_XFER: begin
          if (r_wcnt != WC_LAST) r_wcnt <= r_wcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Capture address (and write-back block) at acceptance; write keeps its own buffer
  // so a write-back never disturbs the last fetched block on dr_data.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE) begin
      if (dw_valid) begin
        r_addr   <= dw_addr;
        r_wr_buf <= dw_data;
      end else if (dr_valid) begin
        r_addr <= dr_addr;
      end
    end
  end

  assign dr_data  = r_rd_buf;
  assign dr_ready = r_dr_ready;
  assign dw_ready = r_dw_ready;

endmodule
